// File: rtl/tt_um_cejmu.sv
// 8-bit accumulator ALU tile: single-cycle logic/arith ops on ACC plus an
// iterative shift-add 8x8 multiply that keeps the low byte.
module tt_um_cejmu #(
    parameter int unsigned MUL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_ROL  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            c_q, c_d;
    logic            s_q, s_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            strobe;
    logic [2:0]      op;
    logic            exec_c;
    logic [DW:0]     add9;
    logic [DW:0]     sub9;
    logic [PW-1:0]   prod_step;
    logic            unused_ok;

    assign strobe    = uio_in[3];
    assign op        = uio_in[2:0];
    assign unused_ok = &{1'b0, uio_in[7:4]};
    assign exec_c    = strobe && !s_q && (state_q == ST_IDLE);

    // State register; rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            c_q      <= 1'b0;
            s_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            s_q      <= s_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: ena=0 leaves every register, including s_q, untouched.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        c_d       = c_q;
        s_d       = s_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        add9      = {1'b0, acc_q} + {1'b0, ui_in};
        sub9      = {1'b0, acc_q} - {1'b0, ui_in};
        prod_step = prod_q + (mplier_q[0] ? mcand_q : PW'(0));

        if (ena) begin
            s_d = strobe;
            case (state_q)
                ST_IDLE: begin
                    if (exec_c) begin
                        case (op)
                            OP_LOAD: acc_d = ui_in;
                            OP_ADD:  {c_d, acc_d} = add9;
                            OP_SUB:  {c_d, acc_d} = sub9;
                            OP_AND:  acc_d = acc_q & ui_in;
                            OP_OR:   acc_d = acc_q | ui_in;
                            OP_XOR:  acc_d = acc_q ^ ui_in;
                            OP_MUL: begin
                                mcand_d  = PW'(acc_q);
                                mplier_d = ui_in;
                                prod_d   = '0;
                                cnt_d    = '0;
                                state_d  = ST_MUL;
                            end
                            OP_ROL:  {c_d, acc_d} = {acc_q, c_q};
                            default: acc_d = acc_q;
                        endcase
                    end
                end
                ST_MUL: begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(MUL_CYCLES - 1)) begin
                        acc_d   = prod_step[DW-1:0];
                        c_d     = |prod_step[PW-1:DW];
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {(state_q == ST_MUL), c_q, acc_q[DW-1], (acc_q == '0), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_cejmu.sv
// Directed bench for tt_um_cejmu: a behavioural ACC/C model pushes expected
// results to a scoreboard that is popped once the DUT has produced them.
module tb_tt_um_cejmu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                           OR_ = 3'd4, XOR_ = 3'd5, MUL = 3'd6, ROL = 3'd7;

    typedef struct {
        logic [7:0] acc;
        logic       c;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    tt_um_cejmu #(.MUL_CYCLES(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] flags(input logic [7:0] a, input logic c, input logic busy);
        return {busy, c, a[7], (a == 8'h00), 4'b0000};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Reference behaviour, written arithmetically rather than as shift-add.
    task automatic model(input logic [2:0] op, input logic [7:0] a);
        logic [15:0] p;
        exp_t e;
        case (op)
            LOAD: m_acc = a;
            ADD:  {m_c, m_acc} = 9'(m_acc) + 9'(a);
            SUB:  begin m_c = (m_acc < a); m_acc = m_acc - a; end
            AND_: m_acc = m_acc & a;
            OR_:  m_acc = m_acc | a;
            XOR_: m_acc = m_acc ^ a;
            MUL:  begin p = 16'(m_acc) * 16'(a); m_acc = p[7:0]; m_c = (p[15:8] != 8'h00); end
            default: {m_c, m_acc} = {m_acc, m_c};
        endcase
        e.acc = m_acc;
        e.c   = m_c;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected pending result", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " acc"}, uo_out, e.acc);
            chk({tag, " flags"}, uio_out, flags(e.acc, e.c, 1'b0));
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (uio_out[7] === 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // One strobed operation; returns with the strobe low and sampled low.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input string tag);
        logic [7:0] old_acc;
        logic       old_c;
        int         n;
        old_acc = m_acc;
        old_c   = m_c;
        ui_in   = a;
        uio_in  = {4'h0, 1'b1, op};
        model(op, a);
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        if (op == MUL) begin
            chk({tag, " busy"}, uio_out, flags(old_acc, old_c, 1'b1));
            @(posedge clk); #1;
            chk({tag, " hold"}, uo_out, old_acc);
            wait_idle(n);
            chk({tag, " cycles"}, 8'(n + 1), 8'd8);
        end
        pop_chk(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        exp_t e;

        // T1: async reset with no clock edge
        #1 rst_n = 1'b1;
        #1;
        chk("reset acc", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h10);
        chk("reset uio_oe", uio_oe, 8'hF0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;

        // T2: add with sign/carry/zero
        do_op(LOAD, 8'h7F, "t2 load");
        do_op(ADD,  8'h01, "t2 add01");
        do_op(ADD,  8'h80, "t2 add80");
        do_op(LOAD, 8'hFF, "wrap load");
        do_op(ADD,  8'h01, "wrap add");
        do_op(LOAD, 8'h00, "wrap load0");
        do_op(SUB,  8'h01, "wrap sub");

        // T3: sub, rotate, logic
        do_op(LOAD, 8'h05, "t3 load");
        do_op(SUB,  8'h06, "t3 sub");
        do_op(ROL,  8'h00, "t3 rol");
        do_op(AND_, 8'h0F, "t3 and");
        do_op(OR_,  8'hA0, "t3 or");
        do_op(XOR_, 8'hA0, "t3 xor1");
        do_op(XOR_, 8'h0F, "t3 xor2");
        do_op(LOAD, 8'h81, "rol load");
        do_op(ROL,  8'h00, "rol a");
        do_op(ROL,  8'h00, "rol b");

        // T4: multiply
        do_op(LOAD, 8'h0C, "t4 load");
        do_op(MUL,  8'h0B, "t4 mul0b");
        do_op(LOAD, 8'h10, "t4 load10");
        do_op(MUL,  8'h10, "t4 mul10");
        do_op(LOAD, 8'hFF, "t4 loadff");
        do_op(MUL,  8'hFF, "t4 mulff");

        // T5a: strobe held high for five cycles produces a single add
        do_op(LOAD, 8'h10, "t5 load");
        ui_in  = 8'h01;
        uio_in = {4'h0, 1'b1, ADD};
        model(ADD, 8'h01);
        repeat (5) @(posedge clk);
        #1 uio_in[3] = 1'b0;
        @(posedge clk); #1;
        pop_chk("t5 held");

        // T5b: strobe during BUSY is dropped
        do_op(LOAD, 8'h03, "t5 load3");
        ui_in  = 8'h05;
        uio_in = {4'h0, 1'b1, MUL};
        model(MUL, 8'h05);
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        @(posedge clk); #1;
        ui_in  = 8'hAA;
        uio_in = {4'h0, 1'b1, LOAD};
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        wait_idle(n);
        pop_chk("t5 busy strobe");
        @(posedge clk); #1;

        // T5c: ena=0 ignores a strobe
        ena    = 1'b0;
        ui_in  = 8'h55;
        uio_in = {4'h0, 1'b1, ADD};
        repeat (2) @(posedge clk);
        #1 uio_in[3] = 1'b0;
        @(posedge clk); #1;
        ena = 1'b1;
        @(posedge clk); #1;
        chk("t5 ena acc", uo_out, m_acc);
        chk("t5 ena flags", uio_out, flags(m_acc, m_c, 1'b0));

        // T6: reset during multiply
        do_op(LOAD, 8'h0C, "t6 load");
        ui_in  = 8'h0B;
        uio_in = {4'h0, 1'b1, MUL};
        model(MUL, 8'h0B);
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6 busy before reset", uio_out, flags(8'h0C, 1'b0, 1'b1));
        rst_n = 1'b1;
        #1;
        chk("t6 reset acc", uo_out, 8'h00);
        chk("t6 reset uio_out", uio_out, 8'h10);
        sb.delete();
        m_acc = 8'h00;
        m_c   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        do_op(LOAD, 8'h22, "t6 load22");
        do_op(ADD,  8'h11, "t6 add");

        e.acc = 8'h00;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard drain: observed %0d left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
